uart_rx_char: RTL and testbench
===============================

Name: uart_rx_char

Overview:
- 8N1 UART receiver that turns the serial line from the host (USB-UART bridge) into bytes for the text display stage.
- Output is a byte plus a one-clock strobe, in exactly the form the text display consumes on its `char`/`en` inputs; it sits directly upstream of that stage.
- Uses 16x oversampling, mid-bit sampling, start-bit glitch rejection and stop-bit framing check.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- OVERSAMPLE, 16, sample ticks per bit. Fixed at 16; other values are unsupported.
- DIV, CLK_FREQ/(BAUD*OVERSAMPLE), integer (truncated) clocks per sample tick. 651 at the defaults.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset. 0 = reset asserted.
- rx  input  1  asynchronous serial line, idle high.
- char  output  8  last correctly received byte.
- en  output  1  one-clock strobe: `char` is new.
- framing_err  output  1  one-clock strobe: stop bit sampled as 0.
- parity_err  output  1  one-clock strobe: parity mismatch. Tied 0 unless UART_RX_PARITY_EN is defined.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: char=0, en=0, framing_err=0, parity_err=0, busy=0.
  - Internal: FSM=IDLE, synchronizer flops=1, tick counter=0, sample counter=0, bit counter=0, shift register=0.
- Synchronizer:
  - `rx` passes through 2 flops before any use; all references below mean the synchronized value.
  - Adds 2 clk of input latency.
- Tick generator:
  - Free-running counter 0..DIV-1.
  - `tick`=1 for one clk when the count equals DIV-1; the counter then wraps to 0.
  - Never stops, including in IDLE.
- Sample counter `s`: 0..15, advances only on tick. Bit counter `n`: 0..7.
- IDLE:
  - busy=0.
  - On a tick with rx=0: go to START, s=0.
- START:
  - On a tick: if s==7 (mid start bit), check rx.
    - rx=0: go to DATA with s=0, n=0.
    - rx=1: glitch; return to IDLE, no strobe.
  - Otherwise s=s+1.
- DATA:
  - On a tick with s==15: shift rx into the shift register MSB (data arrives LSB first), s=0.
    - If n==7: go to STOP (or PARITY when the macro is defined).
    - Otherwise n=n+1.
  - Other ticks: s=s+1.
- STOP: on a tick with s==15:
  - rx=1: char<=shift register, en=1 for the next clk only, go to IDLE.
  - rx=0: framing_err=1 for one clk, char unchanged, go to BREAK.
- BREAK:
  - Wait for rx=1 on a tick, then go to IDLE.
  - A line held low (break condition) therefore produces exactly one framing_err and no spurious frames.
- Latency: en rises about 9.5 bit times after the falling edge of the start bit, plus 2 clk (synchronizer) and at most DIV clk (tick phase).
- Back-to-back frames:
  - A new start bit may begin directly after the stop bit.
  - The return to IDLE at the mid-stop sample leaves half a bit of margin, so no frame is lost.
- Strobes: en, framing_err and parity_err are mutually exclusive and never high for 2 consecutive clk.
- Reset mid-frame: the partial byte is discarded, there is no strobe, and char returns to 0.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: the frame is 8E1. PARITY state follows DATA.
  - On the s==15 tick, compare rx with the XOR of the 8 data bits.
  - Match: go to STOP.
  - Mismatch: latch an error flag and go to STOP.
  - In STOP with rx=1 and the flag set: parity_err pulses for one clk instead of en, and char is unchanged.
  - If the stop bit is also 0, framing_err takes priority.
- Undefined: the PARITY state is absent, the frame is 8N1, and parity_err is constant 0.

Test Plan (CLK_FREQ=1600000, BAUD=10000, so DIV=10 and 1 bit = 160 clk):
- Send 8N1 0x41 -> exactly one en pulse of 1 clk with char=0x41; framing_err=0; busy high for about 1520 clk, then 0.
- Drive rx low for 5 ticks (50 clk), then high -> no en and no framing_err; busy returns to 0 after tick s==7; char stays 0x41.
- Send 0x55 with stop bit=0, hold rx low 2 more bit times, then send 0x0D -> one framing_err pulse, char=0x41 until the 0x0D en pulse, then char=0x0D.
- Send 0x48 then 0x69 with no idle gap -> two en pulses 1600 clk apart, char=0x48 then char=0x69.
- Assert reset=0 during bit 3 of 0x7A, release it, then send 0x31 -> all outputs 0 during reset; no en for 0x7A; one en with char=0x31.
- With UART_RX_PARITY_EN defined: send 0x41 with parity bit 0 -> en, char=0x41. Send 0x41 with parity bit 1 -> parity_err pulse, no en, char unchanged.

Source files
------------

// File: rtl/uart_rx_char.sv
// 8N1 UART receiver, 16x oversampling, mid-bit sampling; emits a byte with a one-clock strobe.
// Optional macro UART_RX_PARITY_EN: 8E1 frames with a parity_err strobe.
module uart_rx_char #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] char,
  output logic       en,
  output logic       framing_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [3:0]    S_LAST    = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]    S_MID     = 4'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BRK
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t          state_reg, state_next;
  logic            rx_meta_reg, rx_sync_reg;
  logic [TW-1:0]   tcnt_reg;
  logic            tick;
  logic [3:0]      s_reg, s_next;
  logic [2:0]      n_reg, n_next;
  logic [7:0]      shift_reg, shift_next;
  logic [7:0]      char_reg, char_next;
  logic            en_reg, en_next;
  logic            fe_reg, fe_next;
`ifdef UART_RX_PARITY_EN
  logic            pe_reg, pe_next;
  logic            pflag_reg, pflag_next;
`endif

  assign tick = (tcnt_reg == TICK_LAST);

  // Synchronizer and free-running tick divider
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      tcnt_reg    <= '0;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      tcnt_reg    <= tick ? '0 : tcnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      shift_reg <= '0;
      char_reg  <= '0;
      en_reg    <= 1'b0;
      fe_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_reg    <= 1'b0;
      pflag_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      shift_reg <= shift_next;
      char_reg  <= char_next;
      en_reg    <= en_next;
      fe_reg    <= fe_next;
`ifdef UART_RX_PARITY_EN
      pe_reg    <= pe_next;
      pflag_reg <= pflag_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    shift_next = shift_reg;
    char_next  = char_reg;
    en_next    = 1'b0;
    fe_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_next    = 1'b0;
    pflag_next = pflag_reg;
`endif
    if (tick) begin
      case (state_reg)
        IDLE: begin
          if (!rx_sync_reg) begin
            state_next = START;
            s_next     = '0;
`ifdef UART_RX_PARITY_EN
            pflag_next = 1'b0;
`endif
          end
        end
        START: begin
          // Mid start bit: a high line here means the falling edge was a glitch
          if (s_reg == S_MID) begin
            if (!rx_sync_reg) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s_reg + 4'd1;
          end
        end
        DATA: begin
          if (s_reg == S_LAST) begin
            shift_next = {rx_sync_reg, shift_reg[7:1]};
            s_next     = '0;
            if (n_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n_reg + 3'd1;
            end
          end else begin
            s_next = s_reg + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_reg == S_LAST) begin
            pflag_next = rx_sync_reg ^ (^shift_reg);
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s_reg + 4'd1;
          end
        end
`endif
        STOP: begin
          // Leaving at mid-stop gives half a bit of margin before a back-to-back start
          if (s_reg == S_LAST) begin
            if (rx_sync_reg) begin
              state_next = IDLE;
`ifdef UART_RX_PARITY_EN
              if (pflag_reg) begin
                pe_next = 1'b1;
              end else begin
                en_next   = 1'b1;
                char_next = shift_reg;
              end
`else
              en_next   = 1'b1;
              char_next = shift_reg;
`endif
            end else begin
              fe_next    = 1'b1;
              state_next = BRK;
            end
          end else begin
            s_next = s_reg + 4'd1;
          end
        end
        BRK: begin
          if (rx_sync_reg) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign char        = char_reg;
  assign en          = en_reg;
  assign framing_err = fe_reg;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = pe_reg;
`else
  assign parity_err  = 1'b0;
`endif
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_char.sv
// Randomized self-checking bench for uart_rx_char: frame-level event model vs observed strobes.
module tb_uart_rx_char;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int BIT      = 160;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] char;
  logic       en, framing_err, parity_err, busy;

  uart_rx_char #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .char(char), .en(en),
    .framing_err(framing_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Events: 1 = en, 2 = framing_err, 3 = parity_err; data = char seen with the strobe
  typedef struct {
    int         kind;
    logic [7:0] data;
    longint     cyc;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  logic [7:0] last_char = 8'h00;
  longint     cyc = 0;
  int         busy_run = 0;
  int         last_busy_len = 0;
  logic       prev_strobe = 1'b0;

  always @(negedge clk) begin
    ev_t e;
    cyc++;
    if (en || framing_err || parity_err) begin
      check("strobe_excl", 32'(en) + 32'(framing_err) + 32'(parity_err), 32'd1);
      check("strobe_width", 32'(prev_strobe), 32'd0);
      e.kind = en ? 1 : (framing_err ? 2 : 3);
      e.data = char;
      e.cyc  = cyc;
      obs_q.push_back(e);
    end
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_busy_len = busy_run;
      busy_run = 0;
    end
    prev_strobe = en | framing_err | parity_err;
  end

  task automatic bits(input int n);
    repeat (n * BIT) @(posedge clk);
  endtask

  // Reference: what one frame on the wire must produce, from frame content alone
  task automatic expect_frame(input logic [7:0] d, input logic stop, input logic par_bad);
    ev_t e;
    if (!stop) begin
      e.kind = 2; e.data = last_char;
    end else if (PAR && par_bad) begin
      e.kind = 3; e.data = last_char;
    end else begin
      e.kind = 1; e.data = d; last_char = d;
    end
    e.cyc = 0;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic par_bad);
    rx = 1'b0; bits(1);
    for (int i = 0; i < 8; i++) begin
      rx = d[i]; bits(1);
    end
    if (PAR) begin
      rx = (^d) ^ par_bad; bits(1);
    end
    rx = stop; bits(1);
  endtask

  task automatic settle_and_compare(input string tag);
    int guard;
    ev_t o, x;
    guard = 0;
    repeat (20) @(posedge clk);
    while (busy && guard < 4000) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      check({tag, "_kind"}, 32'(o.kind), 32'(x.kind));
      check({tag, "_char"}, 32'(o.data), 32'(x.data));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rx = 1'b1;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {20'd0, char, en, framing_err, parity_err, busy}, 32'd0);
    @(posedge clk);
    reset = 1'b1;
    bits(2);

    // Single clean frame
    expect_frame(8'h41, 1'b1, 1'b0);
    send(8'h41, 1'b1, 1'b0);
    settle_and_compare("frame41");
    check("busy_len_41", 32'(last_busy_len), PAR ? 32'd1680 : 32'd1520);
    check("char_41", 32'(char), 32'h41);

    // Start-bit glitch
    rx = 1'b0;
    repeat (50) @(posedge clk);
    rx = 1'b1;
    repeat (200) @(posedge clk);
    settle_and_compare("glitch");
    check("glitch_busy_len", 32'(last_busy_len), 32'd80);
    check("glitch_char", 32'(char), 32'h41);

    // Framing error, held break, recovery
    expect_frame(8'h55, 1'b0, 1'b0);
    send(8'h55, 1'b0, 1'b0);
    rx = 1'b0; bits(2);
    rx = 1'b1; bits(1);
    check("break_char", 32'(char), 32'h41);
    expect_frame(8'h0D, 1'b1, 1'b0);
    send(8'h0D, 1'b1, 1'b0);
    settle_and_compare("break");

    // Back-to-back frames
    expect_frame(8'h48, 1'b1, 1'b0);
    expect_frame(8'h69, 1'b1, 1'b0);
    send(8'h48, 1'b1, 1'b0);
    send(8'h69, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    check("b2b_events", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2)
      check("b2b_spacing", 32'(obs_q[1].cyc - obs_q[0].cyc), PAR ? 32'd1760 : 32'd1600);
    settle_and_compare("b2b");

    // Reset in the middle of bit 3 of 0x7A
    rx = 1'b0; bits(1);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(8'h7A >> i); bits(1);
    end
    rx = 1'(8'h7A >> 3);
    repeat (80) @(posedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("midreset_outs", {20'd0, char, en, framing_err, parity_err, busy}, 32'd0);
    rx = 1'b1;
    @(posedge clk);
    reset = 1'b1;
    last_char = 8'h00;
    bits(2);
    check("midreset_char", 32'(char), 32'h00);
    expect_frame(8'h31, 1'b1, 1'b0);
    send(8'h31, 1'b1, 1'b0);
    settle_and_compare("midreset");

    if (PAR) begin
      expect_frame(8'h41, 1'b1, 1'b0);
      send(8'h41, 1'b1, 1'b0);
      bits(1);
      expect_frame(8'h41, 1'b1, 1'b1);
      send(8'h41, 1'b1, 1'b1);
      settle_and_compare("parity");
      check("parity_char", 32'(char), 32'h41);
    end

    // Randomized traffic: clean, framing-error+break, glitch, parity-error frames
    for (int k = 0; k < 20; k++) begin
      logic [7:0] d;
      int sel;
      d   = 8'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        expect_frame(d, 1'b0, 1'b0);
        send(d, 1'b0, 1'b0);
        rx = 1'b0; bits($urandom_range(0, 2));
        rx = 1'b1; bits(1);
      end else if (sel == 1) begin
        rx = 1'b0;
        repeat ($urandom_range(5, 60)) @(posedge clk);
        rx = 1'b1; bits(1);
      end else if (sel == 2 && PAR) begin
        expect_frame(d, 1'b1, 1'b1);
        send(d, 1'b1, 1'b1);
      end else begin
        expect_frame(d, 1'b1, 1'b0);
        send(d, 1'b1, 1'b0);
      end
      rx = 1'b1;
      bits($urandom_range(0, 2));
    end
    settle_and_compare("random");
    check("random_char", 32'(char), 32'(last_char));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
